seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed 8-digit seven-segment display driver, downstream of the pipelined processor core in pipeline_proc_chip.
- Latches a 32-bit result word from the core and scans it as 8 hex digits onto the board's shared active-low anode and segment pins.
- Runs entirely on the system clock using an internal tick counter; no derived clocks.
- Inserts a ghost-suppression blank gap at every digit switch.

Parameters:
- TICK_DIV, 100000: clock cycles per digit slot. Legal range 4..2^20.
- GAP, 16: cycles at the start of each slot with all anodes off. Must satisfy 1 <= GAP < TICK_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value_i  in  32  word to display; nibble k drives digit k (digit 0 = rightmost)
- load_i  in  1  strobe; latches value_i and dp_i into shadow registers
- dp_i  in  8  decimal point per digit, 1 = lit
- en_i  in  8  digit enable mask, 1 = digit may light
- lz_blank_i  in  1  leading-zero blanking enable
- an_o  out  8  anodes, active-low (an_o[k] maps to an k)
- seg_o  out  7  segments {G,F,E,D,C,B,A}, active-low
- dp_o  out  1  decimal point, active-low
- frame_o  out  1  one-cycle pulse on the last cycle of digit 7's slot

Behaviour:
- Reset (synchronous, active-high), applied on any clk edge including mid-scan. Values after reset:
  - shadow value = 0, shadow dp = 0
  - slot counter cnt = 0, digit index idx = 0
  - an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1, frame_o = 0
- Shadow load:
  - load_i high at edge N → shadow updated at N.
  - New data is visible from the next registered output update; a change mid-slot is allowed.
  - load_i held high reloads every cycle.
- Slot counter:
  - cnt counts 0..TICK_DIV-1. On wrap, cnt = 0 and idx = (idx+1) mod 8.
  - idx 7 wraps to 0.
- Per-slot state machine (derived from cnt):
  - BLANK while cnt < GAP.
  - DRIVE while GAP <= cnt <= TICK_DIV-1.
- Outputs are registered with 1-cycle latency from (cnt, idx, shadow):
  - BLANK: an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1.
  - DRIVE with digit lit: an_o = ~(1<<idx), seg_o = decode(nibble idx), dp_o = ~dp[idx].
  - DRIVE with digit dark: an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1. Scan timing is unchanged; dark slots are not skipped.
- Digit lit condition: en_i[idx] = 1 AND NOT (lz_blank_i AND idx > msd).
  - msd = index of the highest nonzero shadow nibble; msd = 0 when shadow = 0.
  - Digit 0 is never leading-zero blanked.
  - A dp on a blanked digit is not shown.
- Hex decode (active-low {G..A}):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- frame_o: registered. High for the single cycle following the edge where idx = 7 and cnt = TICK_DIV-1.
- Frame period = 8*TICK_DIV cycles.
- No output is ever driven with two anodes low simultaneously.

Test Plan (TICK_DIV=8, GAP=2):
- Reset held 3 cycles, then released → an_o=FF, seg_o=7F, dp_o=1. First anode low (an_o=FE) appears 3 cycles after release; FE lasts 6 cycles; FD follows 2 blank cycles later.
- load_i with value_i=32'h89ABCDEF, en_i=FF, dp_i=0 → over one frame, seg_o per digit 0..7 = 0E,06,21,46,03,08,10,00; frame_o pulses exactly every 64 cycles.
- value_i=32'h00000120, lz_blank_i=1 → digits 0..2 show 40,24,79; digits 3..7 keep an_o=FF for their entire slots. With lz_blank_i=0 → all 8 digits lit, digits 3..7 show 40.
- value_i=0, lz_blank_i=1, dp_i=8'h81 → only digit 0 lit, showing 40 with dp_o=0; digit 7's dp is never shown.
- en_i=8'h0F, value_i=32'h12345678 → digits 4..7 dark; digits 0..3 show 00,78,02,12. load_i of 32'hFFFFFFFF mid-slot of digit 2 → seg_o changes to 0E the cycle after the load edge.
- Reset asserted mid-DRIVE of digit 5 → next cycle an_o=FF, seg_o=7F, frame_o=0. Scan restarts at digit 0 with a full GAP. Over the whole run, an_o never has more than one bit low.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver: latches a 32-bit word and
// scans it as hex digits with a blank gap at every digit switch.
module seg7_scan_driver #(
  parameter int TICK_DIV = 100000,
  parameter int GAP      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_i,
  input  logic        load_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  input  logic        lz_blank_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    BLANK,
    DRIVE
  } slot_state_t;

  slot_state_t   state;
  slot_state_t   state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow_value;
  logic [7:0]    shadow_dp;

  logic [2:0]    msd;
  logic [3:0]    nibble;
  logic          digit_lit;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic          frame_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // The slot phase register always agrees with cnt: BLANK exactly while cnt < GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BLANK;
      cnt          <= '0;
      idx          <= 3'd0;
      shadow_value <= 32'h0;
      shadow_dp    <= 8'h00;
      an_o         <= 8'hFF;
      seg_o        <= 7'h7F;
      dp_o         <= 1'b1;
      frame_o      <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_value <= value_i;
        shadow_dp    <= dp_i;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      state   <= state_next;
      an_o    <= an_next;
      seg_o   <= seg_next;
      dp_o    <= dp_next;
      frame_o <= frame_next;
    end
  end

  always_comb begin
    msd = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (shadow_value[4*k +: 4] != 4'h0) msd = 3'(k);
    end
  end

  assign nibble    = shadow_value[{idx, 2'b00} +: 4];
  assign digit_lit = en_i[idx] && !(lz_blank_i && (idx > msd));

  always_comb begin
    state_next = state;
    an_next    = 8'hFF;
    seg_next   = 7'h7F;
    dp_next    = 1'b1;
    frame_next = (idx == 3'd7) && (cnt == CNT_LAST);
    case (state)
      BLANK: begin
        if (cnt == GAP_LAST) state_next = DRIVE;
      end
      DRIVE: begin
        if (cnt == CNT_LAST) state_next = BLANK;
        // Dark digits keep their full slot so the scan rate never changes.
        if (digit_lit) begin
          an_next  = ~(8'b1 << idx);
          seg_next = hex_to_seg(nibble);
          dp_next  = ~shadow_dp[idx];
        end
      end
      default: state_next = BLANK;
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at TICK_DIV=8, GAP=2: every cycle of
// each frame is compared against hand-computed digit tables.
module tb_seg7_scan_driver;

  localparam int TICK_DIV = 8;
  localparam int GAP      = 2;
  localparam int FRAME    = 8 * TICK_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value_i;
  logic        load_i;
  logic [7:0]  dp_i;
  logic [7:0]  en_i;
  logic        lz_blank_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  int vectors     = 0;
  int miscompares = 0;
  int t           = 0;

  seg7_scan_driver #(
    .TICK_DIV(TICK_DIV),
    .GAP     (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value_i   (value_i),
    .load_i    (load_i),
    .dp_i      (dp_i),
    .en_i      (en_i),
    .lz_blank_i(lz_blank_i),
    .an_o      (an_o),
    .seg_o     (seg_o),
    .dp_o      (dp_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] value, input logic [7:0] dp,
                               input logic [7:0] en, input logic lz, input logic load);
    value_i    = value;
    dp_i       = dp;
    en_i       = en;
    lz_blank_i = lz;
    load_i     = load;
  endtask

  // Output at tick t reflects cnt=(t-1)%8, idx=((t-1)/8)%8 counted from reset release.
  task automatic stepCheck(input logic [55:0] segs, input logic [7:0] lit,
                           input logic [7:0] dps, input string tag);
    int         pos;
    int         c;
    int         d;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_frame;
    @(negedge clk);
    t++;
    pos = (t - 1) % FRAME;
    c   = pos % TICK_DIV;
    d   = pos / TICK_DIV;
    exp_an  = 8'hFF;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    if (c >= GAP && lit[d]) begin
      exp_an  = ~(8'b1 << d);
      exp_seg = segs[d*7 +: 7];
      exp_dp  = ~dps[d];
    end
    exp_frame = ((t % FRAME) == 0);
    checkOutput($sformatf("%s_p%0d_an", tag, pos), {24'h0, an_o}, {24'h0, exp_an});
    checkOutput($sformatf("%s_p%0d_seg", tag, pos), {25'h0, seg_o}, {25'h0, exp_seg});
    checkOutput($sformatf("%s_p%0d_dp", tag, pos), {31'h0, dp_o}, {31'h0, exp_dp});
    checkOutput($sformatf("%s_p%0d_frame", tag, pos), {31'h0, frame_o}, {31'h0, exp_frame});
  endtask

  task automatic runFrame(input logic [55:0] segs, input logic [7:0] lit,
                          input logic [7:0] dps, input string tag);
    for (int i = 0; i < FRAME; i++) begin
      stepCheck(segs, lit, dps, tag);
      load_i = 1'b0;
    end
  endtask

  task automatic checkBlank(input string tag);
    checkOutput({tag, "_an"}, {24'h0, an_o}, 32'hFF);
    checkOutput({tag, "_seg"}, {25'h0, seg_o}, 32'h7F);
    checkOutput({tag, "_dp"}, {31'h0, dp_o}, 32'h1);
    checkOutput({tag, "_frame"}, {31'h0, frame_o}, 32'h0);
  endtask

  always @(negedge clk) begin
    checkOutput("an_onehot", 32'($countones(~an_o) <= 1), 32'h1);
  end

  initial begin
    applyStimulus(32'h0, 8'h00, 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkBlank("reset");

    applyStimulus(32'h89ABCDEF, 8'h00, 8'hFF, 1'b0, 1'b1);
    reset = 1'b0;
    t = 0;
    runFrame({7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF, 8'h00, "hex");

    applyStimulus(32'h00000120, 8'h00, 8'hFF, 1'b1, 1'b1);
    runFrame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40}, 8'h07, 8'h00, "lz_on");
    applyStimulus(32'h00000120, 8'h00, 8'hFF, 1'b0, 1'b0);
    runFrame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40}, 8'hFF, 8'h00, "lz_off");

    applyStimulus(32'h0, 8'h81, 8'hFF, 1'b1, 1'b1);
    runFrame({8{7'h40}}, 8'h01, 8'h81, "zero_dp");

    applyStimulus(32'h43210FED, 8'h5A, 8'hFF, 1'b1, 1'b1);
    runFrame({7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h0E, 7'h06, 7'h21}, 8'hFF, 8'h5A, "dpmix");

    applyStimulus(32'h12345678, 8'h00, 8'h0F, 1'b0, 1'b1);
    runFrame({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'h0F, 8'h00, "en_mask");

    // Reload the same word, then load all-F at cnt=4 of digit 2.
    applyStimulus(32'h12345678, 8'h00, 8'h0F, 1'b0, 1'b1);
    for (int p = 0; p < 20; p++) begin
      stepCheck({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'h0F, 8'h00, "midload");
      load_i = 1'b0;
    end
    applyStimulus(32'hFFFFFFFF, 8'h00, 8'h0F, 1'b0, 1'b1);
    stepCheck({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'h0F, 8'h00, "midload");
    load_i = 1'b0;
    for (int p = 21; p < FRAME; p++) begin
      stepCheck({8{7'h0E}}, 8'h0F, 8'h00, "midload");
    end

    applyStimulus(32'hFFFFFFFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    for (int p = 0; p < 44; p++) begin
      stepCheck({8{7'h0E}}, 8'hFF, 8'h00, "prerst");
    end
    reset = 1'b1;
    @(negedge clk);
    checkBlank("rst_mid");
    reset = 1'b0;
    t = 0;
    runFrame({8{7'h40}}, 8'hFF, 8'h00, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
